// File: rtl/lcd_frame_scheduler.sv
// rtl/lcd_frame_scheduler.sv - streams full framebuffer or clear frames into the LCD driver
// Requests are latched as pending flags; a started frame always runs to its last pixel.
module lcd_frame_scheduler #(
  parameter int          WIDTH       = 320,
  parameter int          HEIGHT      = 240,
  parameter logic [15:0] CLEAR_COLOR = 16'hFFFF,
  parameter int          AW          = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          lcd_initialized_i,
  input  logic          lcd_done_i,
  output logic          lcd_print_o,
  output logic [15:0]   lcd_pixel_rgb_o,
  input  logic          refresh_req_i,
  input  logic          clear_req_i,
  output logic          fb_rd_en_o,
  output logic [AW-1:0] fb_addr_o,
  input  logic [15:0]   fb_rd_data_i,
  output logic          busy_o,
  output logic          frame_done_o
);

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_LOAD      = 3'd3;
  localparam logic [2:0] S_SEND      = 3'd4;
  localparam logic [2:0] S_CLR_SEND  = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [AW-1:0] LAST_PIX = AW'(WIDTH * HEIGHT - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic          clr_pend_q, clr_pend_d;
  logic          print_q, print_d;
  logic [15:0]   rgb_q, rgb_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          accept;

  assign accept = print_q & lcd_done_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ref_pend_d   = ref_pend_q | refresh_req_i;
    clr_pend_d   = clr_pend_q | clear_req_i;
    print_d      = print_q;
    rgb_d        = rgb_q;
    rd_en_d      = 1'b0;
    addr_d       = addr_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_WAIT_INIT: if (lcd_initialized_i) state_d = S_IDLE;
      S_IDLE: begin
        // A request landing on the start cycle re-arms its flag for the next frame.
        if (clr_pend_q) begin
          state_d    = S_CLR_SEND;
          clr_pend_d = clear_req_i;
          cnt_d      = '0;
          busy_d     = 1'b1;
          print_d    = 1'b1;
          rgb_d      = CLEAR_COLOR;
        end else if (ref_pend_q) begin
          state_d    = S_FETCH;
          ref_pend_d = refresh_req_i;
          cnt_d      = '0;
          busy_d     = 1'b1;
          rd_en_d    = 1'b1;
          addr_d     = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        rgb_d   = fb_rd_data_i;
        print_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (accept) begin
          print_d = 1'b0;
          if (cnt_q == LAST_PIX) begin
            state_d      = S_DONE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            rd_en_d = 1'b1;
            addr_d  = cnt_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_CLR_SEND: begin
        if (accept) begin
          print_d = 1'b0;
          if (cnt_q == LAST_PIX) begin
            state_d      = S_DONE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end else begin
          print_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_WAIT_INIT;
      cnt_q        <= '0;
      ref_pend_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
      print_q      <= 1'b0;
      rgb_q        <= '0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ref_pend_q   <= ref_pend_d;
      clr_pend_q   <= clr_pend_d;
      print_q      <= print_d;
      rgb_q        <= rgb_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lcd_print_o     = print_q;
  assign lcd_pixel_rgb_o = rgb_q;
  assign fb_rd_en_o      = rd_en_q;
  assign fb_addr_o       = addr_q;
  assign busy_o          = busy_q;
  assign frame_done_o    = frame_done_q;

endmodule
